reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL expose these parameters:
- DEPTH, 4, number of entries
- PREG_W, 6, physical register index width
- ROB_W, 5, ROB index width
- PAYLOAD_W, 96, opaque decoded-instruction payload width
REQ-002 The block SHALL expose these ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all contents
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  entry available
- dispatch_prs1  in  PREG_W  source-1 physical register
- dispatch_prs2  in  PREG_W  source-2 physical register
- dispatch_rs1_ready  in  1  source-1 value already available
- dispatch_rs2_ready  in  1  source-2 value already available
- dispatch_prd  in  PREG_W  destination physical register
- dispatch_rob_idx  in  ROB_W  ROB tag
- dispatch_payload  in  PAYLOAD_W  decoded instruction
- cdb_valid  in  1  writeback broadcast valid
- cdb_prd  in  PREG_W  physical register being written
- fu_ready  in  1  downstream ALU/CMP unit can accept this cycle
- issue_valid  out  1  issued instruction valid (registered)
- issue_prs1, issue_prs2  out  PREG_W each  register-file read indices (registered)
- issue_prd  out  PREG_W  destination (registered)
- issue_rob_idx  out  ROB_W  ROB tag (registered)
- issue_payload  out  PAYLOAD_W  instruction (registered)
- occupancy  out  clog2(DEPTH+1)  valid entry count

Function
REQ-003 Each entry SHALL hold: valid, prs1, prs2, rdy1, rdy2, prd, rob_idx, payload, and an age order.
REQ-004 dispatch_ready SHALL be 1 iff occupancy < DEPTH; an entry freed by issue in the same cycle SHALL NOT raise dispatch_ready.
REQ-005 On a cycle with dispatch_valid && dispatch_ready && !flush, the block SHALL write one free entry at the rising edge; the choice of free slot SHALL be implementation-defined.
REQ-006 At dispatch, rdyN SHALL be set if dispatch_rsN_ready is 1, or dispatch_prsN == 0, or (cdb_valid && cdb_prd == dispatch_prsN).
REQ-007 Each cycle cdb_valid is 1, every valid entry with prsN == cdb_prd SHALL set rdyN at the edge; cdb_prd == 0 SHALL be ignored.
REQ-008 An entry is eligible when valid && rdy1 && rdy2, using the registered state only; a same-cycle CDB wakeup SHALL NOT make an entry eligible that cycle, which gives 1-cycle wakeup-to-issue.
REQ-009 When fu_ready && !flush and at least one entry is eligible, the block SHALL, at the edge, select the oldest eligible entry (earliest dispatched), load it into the issue_* registers, drive issue_valid=1, and invalidate that entry.
REQ-010 Otherwise issue_valid SHALL be 0 at the edge; other issue_* fields are don't-care when issue_valid=0.
REQ-011 issue_valid SHALL be a one-cycle pulse per instruction, with at most one issue per cycle; no entry SHALL issue twice.
REQ-012 Minimum latency SHALL be: dispatched with both sources ready at edge t -> issue_valid=1 after edge t+1.
REQ-013 Simultaneous dispatch and issue SHALL both occur; occupancy SHALL be unchanged.
REQ-014 occupancy SHALL equal the number of valid entries after each edge, never exceed DEPTH, and never underflow.
REQ-015 Age order SHALL remain correct across arbitrary interleaving of dispatch and out-of-order issue, with no wrap-around error over unbounded runtime.

Reset
REQ-016 rst or flush high at an edge SHALL clear all entry valid bits, issue_valid=0, and occupancy=0; dispatch and CDB inputs that cycle SHALL be ignored.
REQ-017 rst SHALL take priority over all inputs, and reset mid-operation SHALL discard all in-flight entries with no issue the following cycle.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then dispatch prs1=3 rdy, prs2=0, fu_ready=1 -> issue_valid=1 exactly one cycle later, issue_rob_idx matches, occupancy 1->0.
- Dispatch A (prs1=5 not ready) then B (both ready); cdb_prd=5 two cycles later -> B issues first; A issues the cycle after the CDB edge, not the same cycle.
- Dispatch with cdb_valid=1 and cdb_prd=dispatch_prs2=7, rs2_ready=0 -> entry issues next cycle, with no missed wakeup.
- Fill 4 entries with unready sources -> dispatch_ready=0, a 5th dispatch is dropped, occupancy=4; one wakeup plus issue -> dispatch_ready=1 the cycle after.
- fu_ready=0 with 3 eligible entries -> no issue; raise fu_ready -> issues in dispatch order over 3 consecutive cycles.
- Flush with 3 entries and a concurrent dispatch -> occupancy=0, issue_valid=0 next cycle, and no later issue of flushed tags.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station for ALU/CMP ops: holds dispatched instructions and tracks source
// readiness from the CDB. Each cycle it issues the oldest ready entry into registered outputs.
module reservation_station #(
    parameter int DEPTH     = 4,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 96
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [PREG_W-1:0]            dispatch_prs1,
    input  logic [PREG_W-1:0]            dispatch_prs2,
    input  logic                         dispatch_rs1_ready,
    input  logic                         dispatch_rs2_ready,
    input  logic [PREG_W-1:0]            dispatch_prd,
    input  logic [ROB_W-1:0]             dispatch_rob_idx,
    input  logic [PAYLOAD_W-1:0]         dispatch_payload,
    input  logic                         cdb_valid,
    input  logic [PREG_W-1:0]            cdb_prd,
    input  logic                         fu_ready,
    output logic                         issue_valid,
    output logic [PREG_W-1:0]            issue_prs1,
    output logic [PREG_W-1:0]            issue_prs2,
    output logic [PREG_W-1:0]            issue_prd,
    output logic [ROB_W-1:0]             issue_rob_idx,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     e_valid;
    logic [DEPTH-1:0]     e_rdy1;
    logic [DEPTH-1:0]     e_rdy2;
    logic [PREG_W-1:0]    e_prs1    [DEPTH];
    logic [PREG_W-1:0]    e_prs2    [DEPTH];
    logic [PREG_W-1:0]    e_prd     [DEPTH];
    logic [ROB_W-1:0]     e_rob     [DEPTH];
    logic [PAYLOAD_W-1:0] e_payload [DEPTH];
    // older_than[i][j] set means entry j was dispatched before entry i; bits of
    // empty slots are stale but always masked by the eligibility vector.
    logic [DEPTH-1:0]     older_than [DEPTH];

    logic [DEPTH-1:0]     eligible;
    logic [DEPTH-1:0]     oldest;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 issue_found;
    logic [IDX_W-1:0]     issue_idx;
    logic                 do_dispatch;
    logic                 do_issue;
    logic                 cdb_hit;
    logic                 disp_rdy1;
    logic                 disp_rdy2;

    assign dispatch_ready = (occupancy < OCC_W'(DEPTH));
    assign eligible       = e_valid & e_rdy1 & e_rdy2;
    assign cdb_hit        = cdb_valid && (cdb_prd != '0);
    assign disp_rdy1      = dispatch_rs1_ready || (dispatch_prs1 == '0) ||
                            (cdb_valid && (cdb_prd == dispatch_prs1));
    assign disp_rdy2      = dispatch_rs2_ready || (dispatch_prs2 == '0) ||
                            (cdb_valid && (cdb_prd == dispatch_prs2));

    always_comb begin
        oldest      = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = 0; i < DEPTH; i++)
            oldest[i] = eligible[i] && !(|(eligible & older_than[i]));
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!e_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
        do_dispatch = dispatch_valid && dispatch_ready && !flush && free_found;
        do_issue    = fu_ready && !flush && issue_found;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            e_valid     <= '0;
            issue_valid <= 1'b0;
            occupancy   <= '0;
        end else begin
            issue_valid <= do_issue;
            if (do_issue) begin
                issue_prs1         <= e_prs1[issue_idx];
                issue_prs2         <= e_prs2[issue_idx];
                issue_prd          <= e_prd[issue_idx];
                issue_rob_idx      <= e_rob[issue_idx];
                issue_payload      <= e_payload[issue_idx];
                e_valid[issue_idx] <= 1'b0;
            end
            if (cdb_hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (e_prs1[i] == cdb_prd) e_rdy1[i] <= 1'b1;
                    if (e_prs2[i] == cdb_prd) e_rdy2[i] <= 1'b1;
                end
            end
            if (do_dispatch) begin
                e_valid[free_idx]   <= 1'b1;
                e_rdy1[free_idx]    <= disp_rdy1;
                e_rdy2[free_idx]    <= disp_rdy2;
                e_prs1[free_idx]    <= dispatch_prs1;
                e_prs2[free_idx]    <= dispatch_prs2;
                e_prd[free_idx]     <= dispatch_prd;
                e_rob[free_idx]     <= dispatch_rob_idx;
                e_payload[free_idx] <= dispatch_payload;
                // The newcomer is younger than every resident entry.
                for (int i = 0; i < DEPTH; i++)
                    older_than[i][free_idx] <= 1'b0;
                older_than[free_idx] <= ~(DEPTH'(1) << free_idx);
            end
            case ({do_dispatch, do_issue})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed table-driven bench for reservation_station: each row drives one cycle and
// checks the registered outputs just after that rising edge.
module tb_reservation_station;

    localparam int DEPTH = 4, PREG_W = 6, ROB_W = 5, PAYLOAD_W = 96;

    logic                  clk = 1'b0;
    logic                  rst, flush, dispatch_valid, dispatch_ready;
    logic [PREG_W-1:0]     dispatch_prs1, dispatch_prs2, dispatch_prd, cdb_prd;
    logic                  dispatch_rs1_ready, dispatch_rs2_ready, cdb_valid, fu_ready;
    logic [ROB_W-1:0]      dispatch_rob_idx, issue_rob_idx;
    logic [PAYLOAD_W-1:0]  dispatch_payload, issue_payload;
    logic                  issue_valid;
    logic [PREG_W-1:0]     issue_prs1, issue_prs2, issue_prd;
    logic [2:0]            occupancy;

    int errors = 0;
    int checks = 0;

    reservation_station #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_prs1(dispatch_prs1), .dispatch_prs2(dispatch_prs2),
        .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_prd(dispatch_prd), .dispatch_rob_idx(dispatch_rob_idx),
        .dispatch_payload(dispatch_payload),
        .cdb_valid(cdb_valid), .cdb_prd(cdb_prd), .fu_ready(fu_ready),
        .issue_valid(issue_valid), .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
        .issue_prd(issue_prd), .issue_rob_idx(issue_rob_idx), .issue_payload(issue_payload),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, flush, dv;
        logic [5:0] prs1;
        logic       r1;
        logic [5:0] prs2;
        logic       r2;
        logic [4:0] rob;
        logic       cv;
        logic [5:0] cprd;
        logic       fu;
        logic       e_iv;
        logic [4:0] e_rob;
        logic [2:0] e_occ;
        logic       e_dr;
    } vec_t;

    vec_t vq[$];

    function automatic logic [PAYLOAD_W-1:0] pay(input logic [4:0] rob);
        return {32'hCAFE_0000 | 32'(rob), 32'h1234_0000 | (32'(rob) << 3), ~32'(rob)};
    endfunction

    task automatic add(input logic rs, fl, dv, input logic [5:0] p1, input logic r1,
                       input logic [5:0] p2, input logic r2, input logic [4:0] rob,
                       input logic cv, input logic [5:0] cp, input logic fu,
                       input logic eiv, input logic [4:0] erob, input logic [2:0] eocc,
                       input logic edr);
        vec_t v;
        v.rst = rs; v.flush = fl; v.dv = dv; v.prs1 = p1; v.r1 = r1; v.prs2 = p2; v.r2 = r2;
        v.rob = rob; v.cv = cv; v.cprd = cp; v.fu = fu;
        v.e_iv = eiv; v.e_rob = erob; v.e_occ = eocc; v.e_dr = edr;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; flush = v.flush; dispatch_valid = v.dv;
        dispatch_prs1 = v.prs1; dispatch_rs1_ready = v.r1;
        dispatch_prs2 = v.prs2; dispatch_rs2_ready = v.r2;
        dispatch_rob_idx = v.rob; dispatch_prd = 6'(v.rob) + 6'd1;
        dispatch_payload = pay(v.rob);
        cdb_valid = v.cv; cdb_prd = v.cprd; fu_ready = v.fu;
    endtask

    initial begin
        vec_t idle;
        int   lat;
        idle = '{rst:0, flush:0, dv:0, prs1:0, r1:0, prs2:0, r2:0, rob:0, cv:0, cprd:0,
                 fu:1, e_iv:0, e_rob:0, e_occ:0, e_dr:1};
        //   rst fl dv prs1 r1 prs2 r2 rob cv cprd fu | iv rob occ dr
        add(1, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0,  0, 0, 1);
        add(1, 0, 1,  3, 1,  0, 0,  1, 1,  3, 1,   0,  0, 0, 1);
        // single ready dispatch, prs2=0 counts as ready
        add(0, 0, 1,  3, 1,  0, 0,  1, 0,  0, 1,   0,  0, 1, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1,  1, 0, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0,  0, 0, 1);
        // A waits on p5, B ready; wakeup edge does not issue A
        add(0, 0, 1,  5, 0,  0, 0,  2, 0,  0, 1,   0,  0, 1, 1);
        add(0, 0, 1,  1, 1,  2, 1,  3, 0,  0, 1,   0,  0, 2, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1,  5, 1,   1,  3, 1, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1,  2, 0, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0,  0, 0, 1);
        // dispatch-cycle CDB wakeup of prs2
        add(0, 0, 1,  0, 0,  7, 0,  4, 1,  7, 1,   0,  0, 1, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1,  4, 0, 1);
        // fill, dropped 5th dispatch, freed slot not visible same cycle
        add(0, 0, 1, 10, 0,  0, 0,  5, 0,  0, 1,   0,  0, 1, 1);
        add(0, 0, 1, 11, 0,  0, 0,  6, 0,  0, 1,   0,  0, 2, 1);
        add(0, 0, 1, 12, 0,  0, 0,  7, 0,  0, 1,   0,  0, 3, 1);
        add(0, 0, 1, 13, 0,  0, 0,  8, 0,  0, 1,   0,  0, 4, 0);
        add(0, 0, 1,  0, 1,  0, 1,  9, 0,  0, 1,   0,  0, 4, 0);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 12, 1,   0,  0, 4, 0);
        add(0, 0, 1,  0, 1,  0, 1, 15, 0,  0, 1,   1,  7, 3, 1);
        // wake three with fu stalled, then drain in age order
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 10, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 11, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 13, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1,  5, 2, 1);
        add(0, 0, 1, 20, 0,  0, 0, 10, 0,  0, 1,   1,  6, 2, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1,  8, 1, 1);
        // flush with three resident entries and a concurrent dispatch
        add(0, 0, 1, 21, 0,  0, 0, 11, 0,  0, 1,   0,  0, 2, 1);
        add(0, 0, 1,  0, 1,  0, 1, 12, 0,  0, 1,   0,  0, 3, 1);
        add(0, 1, 1,  0, 1,  0, 1, 13, 1, 20, 1,   0,  0, 0, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 21, 1,   0,  0, 0, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0,  0, 0, 1);
        // reset mid-operation discards entries
        add(0, 0, 1,  0, 1,  0, 1, 20, 0,  0, 0,   0,  0, 1, 1);
        add(1, 0, 1,  0, 1,  0, 1, 21, 0,  0, 1,   0,  0, 0, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0,  0, 0, 1);
        // age order survives out-of-order issue and slot reuse
        add(0, 0, 1, 30, 0,  0, 0, 24, 0,  0, 1,   0,  0, 1, 1);
        add(0, 0, 1,  1, 1,  0, 0, 25, 0,  0, 1,   0,  0, 2, 1);
        add(0, 0, 1, 31, 0,  0, 0, 26, 0,  0, 1,   1, 25, 2, 1);
        add(0, 0, 1, 32, 0,  0, 0, 27, 0,  0, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 32, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 31, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 30, 0,   0,  0, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 24, 2, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 26, 1, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 27, 0, 1);
        add(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0,  0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            check($sformatf("row%0d issue_valid", i), 128'(issue_valid), 128'(vq[i].e_iv));
            if (vq[i].e_iv) begin
                check($sformatf("row%0d issue_rob_idx", i), 128'(issue_rob_idx), 128'(vq[i].e_rob));
                check($sformatf("row%0d issue_prd", i), 128'(issue_prd), 128'(6'(vq[i].e_rob) + 6'd1));
                check($sformatf("row%0d issue_payload", i), 128'(issue_payload), 128'(pay(vq[i].e_rob)));
            end
            check($sformatf("row%0d occupancy", i), 128'(occupancy), 128'(vq[i].e_occ));
            check($sformatf("row%0d dispatch_ready", i), 128'(dispatch_ready), 128'(vq[i].e_dr));
        end

        // minimum dispatch-to-issue latency, measured with a bounded wait
        @(negedge clk);
        idle.dv = 1; idle.r1 = 1; idle.r2 = 1; idle.prs1 = 6'd9; idle.prs2 = 6'd10; idle.rob = 5'd22;
        drive(idle);
        @(posedge clk);
        @(negedge clk);
        idle.dv = 0;
        drive(idle);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (issue_valid) begin
                lat = n;
                break;
            end
        end
        check("latency_cycles", 128'(lat), 128'(1));
        check("latency_rob_idx", 128'(issue_rob_idx), 128'(5'd22));
        check("latency_prs1", 128'(issue_prs1), 128'(6'd9));
        check("latency_prs2", 128'(issue_prs2), 128'(6'd10));
        @(posedge clk);
        #1;
        check("latency_single_pulse", 128'(issue_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
